// File: rtl/pin_ctrl_pkg.sv
// Shared constants for the pin_ctrl square-wave subunit: clock rate, pin count,
// reset frequency and the divider datapath width.
package pin_ctrl_pkg;
    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned PIN_NUM  = 20;
    localparam int unsigned FRE_RST  = 1000;
    localparam int unsigned DIV_W    = 32;

    localparam logic [DIV_W-1:0] DIV_NUM  = DIV_W'(CLK_FREQ / 2);
    localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(CLK_FREQ / (2 * FRE_RST));
endpackage

// File: rtl/pin_ctrl_div.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses 33 cycles after start.
// A start while busy restarts with the new operands; divisor 0 yields quotient 0.
module pin_ctrl_div
    import pin_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DIV_W-1:0] quotient_o
);
    logic [DIV_W-1:0] rem_q, quo_q, dvs_q, res_q;
    logic [5:0]       cnt_q;
    logic             busy_q, done_q;
    logic [DIV_W:0]   shift_d, diff_d;
    logic             ge_d;

    // The borrow bit of the trial subtraction decides the next quotient bit.
    always_comb begin
        shift_d = {rem_q, quo_q[DIV_W-1]};
        diff_d  = shift_d - {1'b0, dvs_q};
        ge_d    = ~diff_d[DIV_W];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= '0;
                quo_q  <= dividend_i;
                dvs_q  <= divisor_i;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q == 6'(DIV_W)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    res_q  <= (dvs_q == '0) ? '0 : quo_q;
                end else begin
                    rem_q <= ge_d ? diff_d[DIV_W-1:0] : shift_d[DIV_W-1:0];
                    quo_q <= {quo_q[DIV_W-2:0], ge_d};
                    cnt_q <= cnt_q + 6'd1;
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = res_q;
endmodule

// File: rtl/pin_ctrl_subunit.sv
// Square-wave pin driver: frequency word -> half-period via divider, phase gated by pin mask.
// pins_out registered one cycle behind phase/mask/sw_en; new half-periods apply only on toggle boundaries.
module pin_ctrl_subunit
    import pin_ctrl_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               sw_en,
    input  logic               set_fre_en,
    input  logic [31:0]        set_fre,
    input  logic               set_pins_en,
    input  logic [31:0]        set_pins,
    output logic [PIN_NUM-1:0] pins_out
);
    logic [31:0]        fre_q, half_q, pend_q, cnt_q;
    logic [PIN_NUM-1:0] mask_q, pins_q;
    logic               pend_vld_q, phase_q, fre_en_q, dvz_q;

    logic               div_start, div_busy, div_done;
    logic [DIV_W-1:0]   div_quo;
    logic [31:0]        res_d, pend_d;
    logic               run_d, wrap_d, pend_vld_d, apply_d;
    logic               unused_bits;

    assign unused_bits = ^{set_pins[31:PIN_NUM], div_busy};

    pin_ctrl_div u_div (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .start_i    (div_start),
        .dividend_i (DIV_NUM),
        .divisor_i  (fre_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // A zero quotient from a non-zero divisor means fre > CLK_FREQ/2: clamp to fastest toggle.
    always_comb begin
        div_start  = fre_en_q & ~set_fre_en;
        res_d      = (div_quo == '0 && !dvz_q) ? 32'd1 : div_quo;
        run_d      = sw_en && (half_q != '0);
        wrap_d     = run_d && (cnt_q == half_q - 32'd1);
        pend_d     = div_done ? res_d : pend_q;
        pend_vld_d = div_done | pend_vld_q;
        apply_d    = pend_vld_d && (!sw_en || half_q == '0 || wrap_d);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fre_q      <= FRE_RST;
            mask_q     <= '1;
            half_q     <= HALF_RST;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            pins_q     <= '0;
            fre_en_q   <= 1'b0;
            dvz_q      <= 1'b0;
        end else begin
            fre_en_q <= set_fre_en;
            if (set_fre_en)  fre_q  <= set_fre;
            if (set_pins_en) mask_q <= set_pins[PIN_NUM-1:0];
            if (div_start)   dvz_q  <= (fre_q == '0);

            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d & ~apply_d;
            if (apply_d) half_q <= pend_d;

            if (!run_d) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (wrap_d) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q   <= cnt_q + 32'd1;
            end

            pins_q <= {PIN_NUM{phase_q}} & mask_q & {PIN_NUM{sw_en}};
        end
    end

    assign pins_out = pins_q;
endmodule

// File: tb/tb_pin_ctrl_subunit.sv
// Bench for pin_ctrl_subunit: directed plan scenarios plus random traffic, every cycle
// compared against an event-scheduled model of the pin waveform.
module tb_pin_ctrl_subunit;
    import pin_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sw = 1'b0, fe = 1'b0, pe = 1'b0;
    logic [31:0]        fv = '0, pv = '0;
    logic [PIN_NUM-1:0] pins_out;

    int n_chk = 0;
    int n_pass = 0;

    pin_ctrl_subunit dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .sw_en       (sw),
        .set_fre_en  (fe),
        .set_fre     (fv),
        .set_pins_en (pe),
        .set_pins    (pv),
        .pins_out    (pins_out)
    );

    always #10 clk = ~clk;

    // Model: absolute edge numbers for the next toggle and for divider completion.
    longint             m_n, m_tog, m_res_edge;
    logic [31:0]        m_fre, m_half, m_pend, m_res_val;
    logic [PIN_NUM-1:0] m_mask, m_pins;
    bit                 m_phase, m_pend_vld, m_prev_fe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic m_reset();
        m_fre = FRE_RST;  m_mask = '1;  m_half = CLK_FREQ / (2 * FRE_RST);
        m_pend = '0;  m_pend_vld = 0;  m_phase = 0;  m_prev_fe = 0;
        m_tog = -1;  m_res_edge = -1;  m_pins = '0;
    endtask

    function automatic logic [31:0] half_of(input logic [31:0] f);
        longint q;
        if (f == 0) return 0;
        q = longint'(CLK_FREQ / 2) / longint'(f);
        return (q == 0) ? 32'd1 : 32'(q);
    endfunction

    task automatic model_edge();
        logic [PIN_NUM-1:0] new_pins;
        bit toggle, apply;
        m_n++;
        if (rst) begin m_reset(); return; end
        new_pins = (m_phase ? m_mask : '0) & (sw ? {PIN_NUM{1'b1}} : '0);
        if (m_res_edge == m_n) begin
            m_pend = m_res_val;  m_pend_vld = 1;  m_res_edge = -1;
        end
        if (m_prev_fe && !fe) begin
            m_res_edge = m_n + 34;
            m_res_val  = half_of(m_fre);
        end
        toggle = 0;
        if (sw && m_half != 0) begin
            if (m_tog < 0) m_tog = m_n + longint'(m_half) - 1;
            toggle = (m_n == m_tog);
        end else begin
            m_tog = -1;
        end
        apply = m_pend_vld && (!sw || m_half == 0 || toggle);
        if (toggle) m_phase = !m_phase;
        else if (!sw || m_half == 0) m_phase = 0;
        if (apply) begin m_half = m_pend; m_pend_vld = 0; end
        if (toggle) m_tog = m_n + longint'(m_half);
        if (fe) m_fre = fv;
        if (pe) m_mask = pv[PIN_NUM-1:0];
        m_prev_fe = fe;
        m_pins = new_pins;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pins", 32'(pins_out), 32'(m_pins));
    endtask

    task automatic run_until(input bit want_nz, input int bound, output int k);
        k = 0;
        do begin tick(); k++; end while (((pins_out != '0) != want_nz) && k < bound);
    endtask

    task automatic do_reset(input int hold);
        #3 rst = 1'b1;
        #1 chk("rst_pins", 32'(pins_out), 32'd0);
        m_reset();
        repeat (hold) tick();
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] f, input logic [31:0] m);
        sw = 0; tick();
        fe = 1; fv = f; pe = 1; pv = m;
        repeat (20) tick();
        fe = 0; pe = 0;
        repeat (40) tick();
    endtask

    function automatic logic [31:0] pick_freq();
        int r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return $urandom;
        if (r == 2) return $urandom_range(20_000_000, 50_000_000);
        return $urandom_range(150_000, 12_000_000);
    endfunction

    initial begin
        int k;
        m_n = 0;
        m_reset();

        // 1: reset, then default 1 kHz on all pins
        repeat (10) tick();
        chk("rst_hold", 32'(pins_out), 32'd0);
        rst = 1'b0;
        sw = 1;
        run_until(1, 26000, k);
        chk("t1_first_rise", k, 25001);
        chk("t1_val", 32'(pins_out), 32'hFFFFF);
        run_until(0, 26000, k);
        chk("t1_high_len", k, 25000);

        // 2: 20 MHz with mid-window change, mask AAAAA -> toggle every cycle
        sw = 0; tick();
        fe = 1; fv = 1000; pe = 1; pv = 699050;
        repeat (10) tick();
        pe = 0; fv = 20_000_000;
        repeat (10) tick();
        fe = 0;
        repeat (40) tick();
        sw = 1;
        run_until(1, 10, k);
        chk("t2_lat", k, 2);
        chk("t2_val", 32'(pins_out), 32'hAAAAA);
        run_until(0, 10, k);
        chk("t2_high", k, 1);
        run_until(1, 10, k);
        chk("t2_low", k, 1);

        // 3: 1 MHz on pin 10 only
        cfg(1_000_000, 1024);
        sw = 1;
        run_until(1, 100, k);
        chk("t3_lat", k, 26);
        chk("t3_val", 32'(pins_out), 32'h400);
        run_until(0, 100, k);
        chk("t3_high", k, 25);
        run_until(1, 100, k);
        chk("t3_low", k, 25);

        // 4: DC mode, then resume at 1 kHz while enabled
        cfg(0, 32'hFFFFF);
        sw = 1;
        repeat (200) tick();
        chk("t4_dc", 32'(pins_out), 32'd0);
        fe = 1; fv = 1000;
        repeat (3) tick();
        fe = 0;
        run_until(1, 26000, k);
        chk("t4_resume_lat", k, 25036);

        // 5: 1 MHz -> 500 kHz while running, then a mask change
        cfg(1_000_000, 32'hFFFFF);
        sw = 1;
        run_until(1, 100, k);
        chk("t5_lat", k, 26);
        fe = 1; fv = 500_000; tick();
        fe = 0;
        repeat (80) tick();
        run_until(0, 200, k);
        run_until(1, 200, k);
        chk("t5_low", k, 50);
        run_until(0, 200, k);
        chk("t5_high", k, 50);
        pe = 1; pv = 32'h1; tick();
        pe = 0;
        run_until(1, 200, k);
        chk("t5_mask", 32'(pins_out), 32'h1);

        // 6: reset mid-divide and mid-waveform
        fe = 1; fv = 3_000_000;
        repeat (2) tick();
        fe = 0;
        repeat (10) tick();
        do_reset(10);
        sw = 1;
        repeat (2000) tick();
        chk("t6_post_rst", 32'(pins_out), 32'd0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    fe = 1;
                    repeat ($urandom_range(1, 4)) begin fv = pick_freq(); tick(); end
                    fe = 0;
                end
                1: begin pe = 1; pv = $urandom; tick(); pe = 0; end
                2: begin sw = ~sw; tick(); end
                3: begin
                    fe = 1; pe = 1;
                    repeat ($urandom_range(1, 3)) begin fv = pick_freq(); pv = $urandom; tick(); end
                    fe = 0; pe = 0;
                end
                default: if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 4));
            endcase
            repeat ($urandom_range(1, 150)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pin_ctrl_subunit.md
Name: pin_ctrl_subunit

Overview:
- Programmable square-wave pin driver for a group of PIN_NUM output pins.
- A latched frequency word (Hz) is converted to a half-period count by a sequential divider. A free-running counter toggles a single phase bit, and the phase is gated onto the pins by a latched pin mask.
- Sits behind the AXI/register front-end of the pin_ctrl IP: software writes the frequency and mask, then enables output.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- PIN_NUM, 20, number of output pins (mask width).
- FRE_RST, 1000, reset frequency in Hz.

Ports:
- sys_clk  in  1  system clock; all logic is rising-edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- sw_en  in  1  output enable (level).
- set_fre_en  in  1  frequency write enable (level).
- set_fre  in  32  requested output frequency in Hz.
- set_pins_en  in  1  pin-mask write enable (level).
- set_pins  in  32  pin mask; only bits [PIN_NUM-1:0] are used.
- pins_out  out  PIN_NUM  pin outputs.

Behaviour:
- Interface: one clock (sys_clk); reset sys_rst is asynchronous and active-high.
- Reset values:
  - fre_reg = FRE_RST; mask_reg = all ones.
  - half_reg = CLK_FREQ/(2*FRE_RST), i.e. 25000 at defaults.
  - counter = 0, phase = 0, pins_out = 0, divider idle.
- Frequency write: every cycle set_fre_en=1, fre_reg <= set_fre. The last value present while enable is high wins.
- Divider start: on the falling edge of set_fre_en (registered edge detect), start the divider with numerator CLK_FREQ/2 and denominator fre_reg.
- Divider: restoring, 32-bit unsigned, 1 bit per cycle.
  - done pulses 33 cycles after start.
  - A start while busy aborts and restarts with the new operand.
- Divider result, loaded into half_pend:
  - fre_reg = 0: result is 0, meaning DC mode (phase forced 0, pins_out = 0).
  - quotient = 0, i.e. fre > CLK_FREQ/2: clamp to 1, giving the toggle-every-cycle maximum (CLK_FREQ/2).
  - otherwise the truncated quotient.
  - Examples: 1 MHz -> 25; 20 MHz -> 1 (1.25 truncated).
- Applying half_pend:
  - If sw_en=0, half_pend is copied to half_reg immediately.
  - If sw_en=1, it is copied at the next phase toggle boundary, so no runt pulses.
- Mask write: every cycle set_pins_en=1, mask_reg <= set_pins[PIN_NUM-1:0]. Takes effect on pins_out the next cycle, even while running.
- Output generator:
  - sw_en=0: counter <= 0 and phase <= 0.
  - sw_en=1 and half_reg != 0:
    - counter increments.
    - When counter == half_reg-1: counter <= 0, phase <= ~phase.
    - The first rising edge of phase comes half_reg cycles after sw_en is first sampled high.
- pins_out is registered: pins_out <= {PIN_NUM{phase}} & mask_reg & {PIN_NUM{sw_en}}. Output is therefore low one cycle after sw_en falls.
- Simultaneous events:
  - set_fre_en and set_pins_en high together: both latch independently.
  - sw_en high during a divide: the old half_reg keeps running until done.
- Reset mid-operation: everything returns immediately to reset values, and the divider is aborted.

Decomposition:
- Package pin_ctrl_pkg: CLK_FREQ, PIN_NUM, FRE_RST, divider width (32).
- One sub-module: pin_ctrl_div, a sequential unsigned divider.
  - Inputs: start, dividend, divisor.
  - Outputs: busy, done, quotient.
  - Divisor 0 yields quotient 0.

Test Plan:
1. Reset held 200 ns, then sw_en=1 with default config -> pins_out toggles between 20'hFFFFF and 0 every 25000 cycles (500 us), i.e. 1 kHz. pins_out = 0 during reset.
2. sw_en=0; set_fre_en high for 400 ns with set_fre changed to 20_000_000 mid-window; set_pins=699050 (20'hAAAAA) written via set_pins_en; then sw_en=1 -> half_reg=1, and pins_out alternates 20'hAAAAA / 0 every cycle (25 MHz).
3. Same procedure with set_fre=1_000_000, set_pins=1024 -> only pins_out[10] toggles, 25 cycles high and 25 low (1 MHz).
4. set_fre=0 written, sw_en=1 -> pins_out stays 0. Then write set_fre=1000 -> toggling resumes at 1 kHz.
5. While running at 1 MHz, write 500_000 Hz -> the next half-period after the current toggle is 50 cycles, with no shortened pulse. A mask change to 20'h00001 is visible one cycle after set_pins_en.
6. Assert sys_rst mid-divide and mid-waveform -> pins_out = 0 immediately; after release the config is back to 1 kHz / all-ones.
